// File: rtl/simple_processor_pkg.sv
`default_nettype none
// ============================================================================
// Package     : simple_processor_pkg
// Description : Shared widths and types for the simple processor datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package simple_processor_pkg;

    // Width of every architectural data word and ALU result
    localparam int DATA_WIDTH      = 32;

    // Default number of architectural registers
    localparam int NUM_REG_DEFAULT = 8;

    // Register index width for the default register count
    localparam int REG_ADDR_WIDTH  = $clog2(NUM_REG_DEFAULT);

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;

endpackage : simple_processor_pkg
`default_nettype wire

// File: rtl/reg_file_if.sv
`default_nettype none
// ============================================================================
// Interface   : reg_file_if
// Description : Operand read / result writeback / issue bundle between the
//               issue+ALU side (master) and the register file (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface reg_file_if
    import simple_processor_pkg::*;
#(
    parameter int NUM_REG = NUM_REG_DEFAULT
);
    localparam int c_ADDR_W = $clog2(NUM_REG);

    logic [c_ADDR_W-1:0]   rs1_addr_i;
    logic [c_ADDR_W-1:0]   rs2_addr_i;
    logic                  rs1_used_i;
    logic                  rs2_used_i;
    logic [DATA_WIDTH-1:0] rs1_data_o;
    logic [DATA_WIDTH-1:0] rs2_data_o;
    logic [c_ADDR_W-1:0]   rd_addr_i;
    logic                  rd_issue_i;
    logic                  wb_en_i;
    logic [c_ADDR_W-1:0]   wb_addr_i;
    logic [DATA_WIDTH-1:0] wb_data_i;
    logic                  rs1_busy_o;
    logic                  rs2_busy_o;
    logic                  stall_o;

    modport master (
        output rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
        output rd_addr_i, rd_issue_i, wb_en_i, wb_addr_i, wb_data_i,
        input  rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, stall_o
    );

    modport slave (
        input  rs1_addr_i, rs2_addr_i, rs1_used_i, rs2_used_i,
        input  rd_addr_i, rd_issue_i, wb_en_i, wb_addr_i, wb_data_i,
        output rs1_data_o, rs2_data_o, rs1_busy_o, rs2_busy_o, stall_o
    );

endinterface : reg_file_if
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register pending-write flags with hazard/stall lookup.
//               A writeback in the same cycle satisfies a pending operand.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int NUM_REG  = 8,
    parameter bit ZERO_REG = 1'b1,
    parameter int ADDR_W   = $clog2(NUM_REG)
) (
    input  wire logic              clk_i,
    input  wire logic              arst_ni,
    input  wire logic [ADDR_W-1:0] rs1_addr_i,
    input  wire logic [ADDR_W-1:0] rs2_addr_i,
    input  wire logic              rs1_used_i,
    input  wire logic              rs2_used_i,
    input  wire logic [ADDR_W-1:0] rd_addr_i,
    input  wire logic              rd_issue_i,
    input  wire logic              wb_en_i,
    input  wire logic [ADDR_W-1:0] wb_addr_i,
    output logic                   rs1_busy_o,
    output logic                   rs2_busy_o,
    output logic                   stall_o
);

    logic [NUM_REG-1:0] busy_q;
    logic [NUM_REG-1:0] busy_d;
    logic               waw;

    // Hazard lookup: a matching writeback this cycle retires the pending write
    always_comb begin
        rs1_busy_o = busy_q[rs1_addr_i] && !(wb_en_i && (wb_addr_i == rs1_addr_i));
        rs2_busy_o = busy_q[rs2_addr_i] && !(wb_en_i && (wb_addr_i == rs2_addr_i));
        waw        = rd_issue_i && busy_q[rd_addr_i]
                     && !(wb_en_i && (wb_addr_i == rd_addr_i));
        stall_o    = (rs1_used_i && rs1_busy_o) || (rs2_used_i && rs2_busy_o) || waw;
    end

    // Next busy state: clear on writeback, then set on accepted issue (set wins)
    always_comb begin
        busy_d = busy_q;
        if (wb_en_i) begin
            busy_d[wb_addr_i] = 1'b0;
        end
        if (rd_issue_i && !stall_o) begin
            busy_d[rd_addr_i] = 1'b1;
        end
        if (ZERO_REG) begin
            busy_d[0] = 1'b0;
        end
    end

    // Busy flags; reset forgets every outstanding write
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module      : reg_file
// Description : Architectural register file with write-through bypass and a
//               pending-write scoreboard driving the issue stall.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file
    import simple_processor_pkg::*;
#(
    parameter int NUM_REG  = NUM_REG_DEFAULT,
    parameter bit ZERO_REG = 1'b1
) (
    input  wire logic  clk_i,
    input  wire logic  arst_ni,
    reg_file_if.slave  rf
);

    localparam int c_ADDR_W = $clog2(NUM_REG);

    logic [DATA_WIDTH-1:0] regs_q [NUM_REG];
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rs1_data;
    logic [DATA_WIDTH-1:0] rs2_data;

    // Hardwired zero register silently drops its writes
    assign wr_en = rf.wb_en_i && !(ZERO_REG && (rf.wb_addr_i == '0));

    // Single full-word write port
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            for (int i = 0; i < NUM_REG; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[rf.wb_addr_i] <= rf.wb_data_i;
        end
    end

    // Combinational reads; same-cycle writeback is forwarded except to r0
    always_comb begin
        rs1_data = regs_q[rf.rs1_addr_i];
        rs2_data = regs_q[rf.rs2_addr_i];
        if (wr_en && (rf.wb_addr_i == rf.rs1_addr_i)) begin
            rs1_data = rf.wb_data_i;
        end
        if (wr_en && (rf.wb_addr_i == rf.rs2_addr_i)) begin
            rs2_data = rf.wb_data_i;
        end
    end

    assign rf.rs1_data_o = rs1_data;
    assign rf.rs2_data_o = rs2_data;

    reg_scoreboard #(
        .NUM_REG  (NUM_REG),
        .ZERO_REG (ZERO_REG),
        .ADDR_W   (c_ADDR_W)
    ) u_scoreboard (
        .clk_i      (clk_i),
        .arst_ni    (arst_ni),
        .rs1_addr_i (rf.rs1_addr_i),
        .rs2_addr_i (rf.rs2_addr_i),
        .rs1_used_i (rf.rs1_used_i),
        .rs2_used_i (rf.rs2_used_i),
        .rd_addr_i  (rf.rd_addr_i),
        .rd_issue_i (rf.rd_issue_i),
        .wb_en_i    (rf.wb_en_i),
        .wb_addr_i  (rf.wb_addr_i),
        .rs1_busy_o (rf.rs1_busy_o),
        .rs2_busy_o (rf.rs2_busy_o),
        .stall_o    (rf.stall_o)
    );

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file
// Description : Self-checking bench for reg_file against an array-based
//               reference model, directed scenarios plus random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file;
    import simple_processor_pkg::*;

    logic clk_i   = 1'b0;
    logic arst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    reg_file_if #(.NUM_REG(8)) rf ();

    reg_file #(.NUM_REG(8), .ZERO_REG(1'b1)) dut (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .rf      (rf)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] m_regs [8];
    bit          m_busy [8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endfunction

    function automatic bit wb_hits(input int a);
        return rf.wb_en_i && (int'(rf.wb_addr_i) == a);
    endfunction

    function automatic logic [31:0] exp_data(input int a);
        if (a == 0)      return 32'h0;
        if (wb_hits(a))  return rf.wb_data_i;
        return m_regs[a];
    endfunction

    function automatic bit exp_busy(input int a);
        return m_busy[a] && !wb_hits(a);
    endfunction

    function automatic bit exp_stall();
        int  a1 = int'(rf.rs1_addr_i);
        int  a2 = int'(rf.rs2_addr_i);
        int  rd = int'(rf.rd_addr_i);
        bit  waw = rf.rd_issue_i && exp_busy(rd);
        return (rf.rs1_used_i && exp_busy(a1)) || (rf.rs2_used_i && exp_busy(a2)) || waw;
    endfunction

    task automatic drive(input int a1, input int a2, input bit u1, input bit u2,
                         input int rd, input bit iss,
                         input bit wen, input int wa, input logic [31:0] wd);
        rf.rs1_addr_i = 3'(a1);
        rf.rs2_addr_i = 3'(a2);
        rf.rs1_used_i = u1;
        rf.rs2_used_i = u2;
        rf.rd_addr_i  = 3'(rd);
        rf.rd_issue_i = iss;
        rf.wb_en_i    = wen;
        rf.wb_addr_i  = 3'(wa);
        rf.wb_data_i  = wd;
    endtask

    // Check all outputs mid-cycle, then clock the edge and advance the model
    task automatic cycle(input string tag);
        bit st;
        int wa;
        int rd;
        #2;
        st = exp_stall();
        check({tag, ".rs1_data"}, rf.rs1_data_o, exp_data(int'(rf.rs1_addr_i)));
        check({tag, ".rs2_data"}, rf.rs2_data_o, exp_data(int'(rf.rs2_addr_i)));
        check({tag, ".rs1_busy"}, 32'(rf.rs1_busy_o), 32'(exp_busy(int'(rf.rs1_addr_i))));
        check({tag, ".rs2_busy"}, 32'(rf.rs2_busy_o), 32'(exp_busy(int'(rf.rs2_addr_i))));
        check({tag, ".stall"},    32'(rf.stall_o),    32'(st));
        wa = int'(rf.wb_addr_i);
        rd = int'(rf.rd_addr_i);
        @(posedge clk_i);
        if (rf.wb_en_i && wa != 0) m_regs[wa] = rf.wb_data_i;
        if (rf.wb_en_i)            m_busy[wa] = 1'b0;
        if (rf.rd_issue_i && !st && rd != 0) m_busy[rd] = 1'b1;
        #1;
    endtask

    // Asynchronous reset between clock edges; outputs must clear at once
    task automatic async_reset(input string tag);
        @(negedge clk_i);
        #1;
        drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
        arst_ni = 1'b0;
        model_reset();
        #1;
        for (int a = 0; a < 8; a++) begin
            drive(a, 7 - a, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 32'h0);
            #1;
            check({tag, ".rs1_data"}, rf.rs1_data_o, 32'h0);
            check({tag, ".rs2_data"}, rf.rs2_data_o, 32'h0);
            check({tag, ".stall"},    32'(rf.stall_o), 32'h0);
        end
        @(negedge clk_i);
        arst_ni = 1'b1;
        drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        model_reset();
        drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
        #1;
        // Reset state for every index
        for (int a = 0; a < 8; a++) begin
            drive(a, a, 1'b1, 1'b1, 0, 1'b0, 1'b0, 0, 32'h0);
            #1;
            check("rst.rs1_data", rf.rs1_data_o, 32'h0);
            check("rst.rs2_data", rf.rs2_data_o, 32'h0);
            check("rst.stall",    32'(rf.stall_o), 32'h0);
        end
        @(negedge clk_i);
        arst_ni = 1'b1;
        drive(0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
        @(posedge clk_i);
        #1;

        // Write r3 with same-cycle bypass, then plain read
        drive(3, 3, 1'b1, 1'b1, 0, 1'b0, 1'b1, 3, 32'h0000_00A5);
        cycle("wr_r3_bypass");
        check("r3_bypass_const", rf.rs1_data_o, 32'h0000_00A5);
        drive(3, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
        cycle("rd_r3");
        check("r3_read_const", rf.rs1_data_o, 32'h0000_00A5);

        // Zero register ignores writes and issues
        drive(0, 0, 1'b1, 1'b1, 0, 1'b1, 1'b1, 0, 32'hFFFF_FFFF);
        cycle("r0_wr_issue");
        drive(0, 0, 1'b1, 1'b1, 0, 1'b1, 1'b0, 0, 32'h0);
        cycle("r0_read");
        check("r0_stall_const", 32'(rf.stall_o), 32'h0);

        // RAW on r5 resolved by same-cycle writeback
        drive(0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b0, 0, 32'h0);
        cycle("issue_r5");
        drive(5, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
        cycle("raw_r5_stall");
        drive(5, 0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 5, 32'h0000_1234);
        cycle("raw_r5_wb");
        drive(5, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
        cycle("r5_cleared");

        // ADDI ignores busy rs2; WAW stall leaves scoreboard untouched
        drive(0, 0, 1'b0, 1'b0, 5, 1'b1, 1'b0, 0, 32'h0);
        cycle("reissue_r5");
        drive(1, 5, 1'b1, 1'b0, 6, 1'b0, 1'b0, 0, 32'h0);
        cycle("addi_rs2_unused");
        drive(1, 0, 1'b1, 1'b0, 5, 1'b1, 1'b0, 0, 32'h0);
        cycle("waw_r5");
        drive(5, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
        cycle("r5_still_busy");

        // Same-cycle writeback and reissue of r2: set wins
        drive(0, 0, 1'b0, 1'b0, 2, 1'b1, 1'b0, 0, 32'h0);
        cycle("issue_r2");
        drive(0, 0, 1'b0, 1'b0, 2, 1'b1, 1'b1, 2, 32'hCAFE_0002);
        cycle("wb_reissue_r2");
        drive(2, 2, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
        cycle("r2_rebusy");

        async_reset("midrst");

        // Late writeback after reset writes data but stays not busy
        drive(5, 0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 5, 32'h0BAD_F00D);
        cycle("late_wb");
        drive(5, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0, 32'h0);
        cycle("late_wb_read");

        // Random traffic biased toward hazards
        for (int n = 0; n < 600; n++) begin
            if (n == 300) async_reset("rnd_rst");
            drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)), ($urandom_range(0, 99) < 50),
                  ($urandom_range(0, 99) < 40), int'($urandom_range(0, 7)),
                  $urandom());
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire
